mips_multicycle_control: RTL and testbench

- Next-generation control unit for the multi-cycle MIPS core.
- Replaces the single-cycle opcode/funct decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Waits on a memory acknowledge handshake and on a fixed-latency multiply/divide unit.
- Sits between the instruction register and the shared multi-cycle datapath (PC, IR, ALU, register file, HI/LO).

---
 rtl/mips_mc_ctrl_pkg.sv | 153 +++++++++++++++
 rtl/mips_mc_muldiv_timer.sv | 27 ++
 rtl/mips_multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, ALU ops, mux selects,
// opcode/funct values and instruction classification helpers.
package mips_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExec     = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10,
        StMuldiv   = 4'd11,
        StTrap     = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ClsLoad, ClsStore, ClsAlu, ClsBranch, ClsJump, ClsIllegal
    } instr_class_e;

    localparam logic [5:0] AluAdd  = 6'b000000;
    localparam logic [5:0] AluSub  = 6'b000001;
    localparam logic [5:0] AluSll  = 6'b000010;
    localparam logic [5:0] AluSrl  = 6'b000100;
    localparam logic [5:0] AluSra  = 6'b000110;
    localparam logic [5:0] AluOr   = 6'b001000;
    localparam logic [5:0] AluAnd  = 6'b010000;
    localparam logic [5:0] AluNor  = 6'b011000;
    localparam logic [5:0] AluXor  = 6'b100000;
    localparam logic [5:0] AluSlt  = 6'b101001;
    localparam logic [5:0] AluSltu = 6'b110001;

    localparam logic [2:0] SrcBRt    = 3'b000;
    localparam logic [2:0] SrcBImm   = 3'b001;
    localparam logic [2:0] SrcBShamt = 3'b010;
    localparam logic [2:0] SrcBImmSh = 3'b011;
    localparam logic [2:0] SrcBZero  = 3'b100;
    localparam logic [2:0] SrcBFour  = 3'b101;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcRs     = 2'b11;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpRegimm = 6'h01;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpBlez  = 6'h06;
    localparam logic [5:0] OpBgtz  = 6'h07;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpSltiu = 6'h0b;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpLh    = 6'h21;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpLbu   = 6'h24;
    localparam logic [5:0] OpLhu   = 6'h25;
    localparam logic [5:0] OpSb    = 6'h28;
    localparam logic [5:0] OpSh    = 6'h29;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll     = 6'h00;
    localparam logic [5:0] FnSrl     = 6'h02;
    localparam logic [5:0] FnSra     = 6'h03;
    localparam logic [5:0] FnSllv    = 6'h04;
    localparam logic [5:0] FnSrlv    = 6'h06;
    localparam logic [5:0] FnSrav    = 6'h07;
    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnJalr    = 6'h09;
    localparam logic [5:0] FnSyscall = 6'h0c;
    localparam logic [5:0] FnMthi    = 6'h11;
    localparam logic [5:0] FnMtlo    = 6'h13;
    localparam logic [5:0] FnMult    = 6'h18;
    localparam logic [5:0] FnMultu   = 6'h19;
    localparam logic [5:0] FnDiv     = 6'h1a;
    localparam logic [5:0] FnDivu    = 6'h1b;
    localparam logic [5:0] FnAdd     = 6'h20;
    localparam logic [5:0] FnAddu    = 6'h21;
    localparam logic [5:0] FnSub     = 6'h22;
    localparam logic [5:0] FnSubu    = 6'h23;
    localparam logic [5:0] FnAnd     = 6'h24;
    localparam logic [5:0] FnOr      = 6'h25;
    localparam logic [5:0] FnXor     = 6'h26;
    localparam logic [5:0] FnNor     = 6'h27;
    localparam logic [5:0] FnSlt     = 6'h2a;
    localparam logic [5:0] FnSltu    = 6'h2b;

    function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] funct);
        instr_class_e cls;
        case (op)
            OpRtype:                                  cls = (funct == FnJr || funct == FnJalr) ?
                                                            ClsJump : ClsAlu;
            OpJ, OpJal:                               cls = ClsJump;
            OpRegimm, OpBeq, OpBne, OpBlez, OpBgtz:   cls = ClsBranch;
            OpAddi, OpAddiu, OpSlti, OpSltiu,
            OpAndi, OpOri, OpXori:                    cls = ClsAlu;
            OpLb, OpLh, OpLw, OpLbu, OpLhu:           cls = ClsLoad;
            OpSb, OpSh, OpSw:                         cls = ClsStore;
            default:                                  cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    function automatic logic is_shift(input logic [5:0] funct);
        return funct inside {FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav};
    endfunction

    function automatic logic [5:0] exec_alu_op(input logic [5:0] op, input logic [5:0] funct);
        logic [5:0] alu;
        alu = AluAdd;
        if (op == OpRtype) begin
            case (funct)
                FnSub, FnSubu:  alu = AluSub;
                FnAnd:          alu = AluAnd;
                FnOr:           alu = AluOr;
                FnXor:          alu = AluXor;
                FnNor:          alu = AluNor;
                FnSlt:          alu = AluSlt;
                FnSltu:         alu = AluSltu;
                FnSll, FnSllv:  alu = AluSll;
                FnSrl, FnSrlv:  alu = AluSrl;
                FnSra, FnSrav:  alu = AluSra;
                default:        alu = AluAdd;
            endcase
        end else begin
            case (op)
                OpSlti:  alu = AluSlt;
                OpSltiu: alu = AluSltu;
                OpAndi:  alu = AluAnd;
                OpOri:   alu = AluOr;
                OpXori:  alu = AluXor;
                default: alu = AluAdd;
            endcase
        end
        return alu;
    endfunction

endpackage

// File: rtl/mips_mc_muldiv_timer.sv
// Down-counter that times the fixed-latency mult/div unit; done while the count reads zero.
module mips_mc_muldiv_timer #(
    parameter int unsigned CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam logic [7:0] LoadVal = 8'(CYCLES - 1);

    logic [7:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= LoadVal;
        end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign done = (count_q == 8'd0);

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Defining MIPS_MC_CTRL_EXC_EN adds
// exc_ctl_o and turns TRAP (illegal opcode, SYSCALL) into an exception-vector jump.
module mips_multicycle_control
    import mips_mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W      = 6,
    parameter int unsigned ALU_SRC_W     = 3,
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           instr_op_ctl_i,
    input  logic [5:0]           instr_funct_ctl_i,
    input  logic                 mem_ack_i,
    output logic                 pc_wr_ctl_o,
    output logic                 pc_wr_cond_ctl_o,
    output logic [1:0]           pc_src_ctl_o,
    output logic                 ir_wr_ctl_o,
    output logic                 iord_ctl_o,
    output logic                 mem_read_ctl_o,
    output logic                 mem_wr_ctl_o,
    output logic                 mem_to_reg_ctl_o,
    output logic [1:0]           reg_dst_ctl_o,
    output logic                 reg_wr_ctl_o,
    output logic                 alu_src_a_ctl_o,
    output logic [ALU_SRC_W-1:0] alu_src_b_ctl_o,
    output logic [ALU_OP_W-1:0]  alu_op_ctl_o,
    output logic                 sign_ext_ctl_o,
    output logic                 muldiv_start_ctl_o,
    output logic [3:0]           state_o
`ifdef MIPS_MC_CTRL_EXC_EN
    ,
    output logic                 exc_ctl_o
`endif
);

    state_e       state_q;
    instr_class_e cls;
    logic         is_rtype, is_muldiv, is_syscall, is_mthilo, is_jal, is_jalr;
    logic         muldiv_load, muldiv_done;

    assign cls        = classify(instr_op_ctl_i, instr_funct_ctl_i);
    assign is_rtype   = (instr_op_ctl_i == OpRtype);
    assign is_muldiv  = is_rtype && (instr_funct_ctl_i inside {FnMult, FnMultu, FnDiv, FnDivu});
    assign is_syscall = is_rtype && (instr_funct_ctl_i == FnSyscall);
    assign is_mthilo  = is_rtype && (instr_funct_ctl_i inside {FnMthi, FnMtlo});
    assign is_jal     = (instr_op_ctl_i == OpJal);
    assign is_jalr    = is_rtype && (instr_funct_ctl_i == FnJalr);

    assign muldiv_load = (state_q == StExec) && is_muldiv;

    mips_mc_muldiv_timer #(
        .CYCLES (MULDIV_CYCLES)
    ) u_muldiv_timer (
        .clk   (clk),
        .reset (reset),
        .load  (muldiv_load),
        .done  (muldiv_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:     state_q <= StFetch;
                StFetch:    if (mem_ack_i) state_q <= StDecode;
                StDecode: begin
                    case (cls)
                        ClsLoad, ClsStore: state_q <= StMemAddr;
                        ClsAlu:            state_q <= StExec;
                        ClsBranch:         state_q <= StBranch;
                        ClsJump:           state_q <= StJump;
                        default:           state_q <= StTrap;
                    endcase
                end
                StMemAddr:  state_q <= (cls == ClsLoad) ? StMemRead : StMemWrite;
                StMemRead:  if (mem_ack_i) state_q <= StMemWb;
                StMemWrite: if (mem_ack_i) state_q <= StFetch;
                StExec: begin
                    if (is_muldiv) begin
                        state_q <= StMuldiv;
                    end else if (is_syscall) begin
`ifdef MIPS_MC_CTRL_EXC_EN
                        state_q <= StTrap;
`else
                        state_q <= StFetch;
`endif
                    end else if (is_mthilo) begin
                        state_q <= StFetch;
                    end else begin
                        state_q <= StAluWb;
                    end
                end
                StMuldiv:   if (muldiv_done) state_q <= StFetch;
                StMemWb, StAluWb, StBranch, StJump, StTrap: state_q <= StFetch;
                default:    state_q <= StIdle;
            endcase
        end
    end

    // Outputs depend only on the state and the held IR fields, plus the FETCH ack strobe.
    always_comb begin
        pc_wr_ctl_o        = 1'b0;
        pc_wr_cond_ctl_o   = 1'b0;
        pc_src_ctl_o       = PcSrcAlu;
        ir_wr_ctl_o        = 1'b0;
        iord_ctl_o         = 1'b0;
        mem_read_ctl_o     = 1'b0;
        mem_wr_ctl_o       = 1'b0;
        mem_to_reg_ctl_o   = 1'b0;
        reg_dst_ctl_o      = RegDstRt;
        reg_wr_ctl_o       = 1'b0;
        alu_src_a_ctl_o    = 1'b0;
        alu_src_b_ctl_o    = ALU_SRC_W'(SrcBRt);
        alu_op_ctl_o       = ALU_OP_W'(AluAdd);
        sign_ext_ctl_o     = 1'b0;
        muldiv_start_ctl_o = 1'b0;
`ifdef MIPS_MC_CTRL_EXC_EN
        exc_ctl_o          = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                mem_read_ctl_o  = 1'b1;
                alu_src_b_ctl_o = ALU_SRC_W'(SrcBFour);
                ir_wr_ctl_o     = mem_ack_i;
                pc_wr_ctl_o     = mem_ack_i;
            end
            StDecode: alu_src_b_ctl_o = ALU_SRC_W'(SrcBImmSh);
            StMemAddr: begin
                alu_src_a_ctl_o = 1'b1;
                alu_src_b_ctl_o = ALU_SRC_W'(SrcBImm);
                sign_ext_ctl_o  = 1'b1;
            end
            StMemRead: begin
                mem_read_ctl_o = 1'b1;
                iord_ctl_o     = 1'b1;
            end
            StMemWb: begin
                reg_wr_ctl_o     = 1'b1;
                mem_to_reg_ctl_o = 1'b1;
            end
            StMemWrite: begin
                mem_wr_ctl_o = 1'b1;
                iord_ctl_o   = 1'b1;
            end
            StExec: begin
                alu_src_a_ctl_o = 1'b1;
                alu_op_ctl_o    = ALU_OP_W'(exec_alu_op(instr_op_ctl_i, instr_funct_ctl_i));
                if (is_rtype) begin
                    alu_src_b_ctl_o    = is_shift(instr_funct_ctl_i) ? ALU_SRC_W'(SrcBShamt) :
                                                                       ALU_SRC_W'(SrcBRt);
                    muldiv_start_ctl_o = is_muldiv;
                end else begin
                    alu_src_b_ctl_o = ALU_SRC_W'(SrcBImm);
                    sign_ext_ctl_o  = !(instr_op_ctl_i inside {OpAndi, OpOri, OpXori});
                end
            end
            StAluWb: begin
                reg_wr_ctl_o  = 1'b1;
                reg_dst_ctl_o = is_rtype ? RegDstRd : RegDstRt;
            end
            StBranch: begin
                alu_src_a_ctl_o  = 1'b1;
                pc_wr_cond_ctl_o = 1'b1;
                pc_src_ctl_o     = PcSrcAluOut;
                alu_op_ctl_o     = ALU_OP_W'(AluSub);
                alu_src_b_ctl_o  = (instr_op_ctl_i inside {OpBeq, OpBne}) ? ALU_SRC_W'(SrcBRt) :
                                                                            ALU_SRC_W'(SrcBZero);
            end
            StJump: begin
                pc_wr_ctl_o  = 1'b1;
                pc_src_ctl_o = is_rtype ? PcSrcRs : PcSrcJump;
                // Link: the ALU forms the return address from the PC while the jump commits.
                if (is_jal || is_jalr) begin
                    reg_wr_ctl_o    = 1'b1;
                    alu_src_b_ctl_o = ALU_SRC_W'(SrcBFour);
                    reg_dst_ctl_o   = is_jal ? RegDstRa : RegDstRd;
                end
            end
            StTrap: begin
`ifdef MIPS_MC_CTRL_EXC_EN
                exc_ctl_o   = 1'b1;
                pc_wr_ctl_o = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: an instruction-level model expands each instruction into its expected
// per-cycle control trace, which is compared against the DUT every cycle.
module tb_mips_multicycle_control;

    localparam int unsigned MdCycles = 4;

    localparam logic [5:0] OP_R = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b, OP_BAD = 6'h3f;
    localparam logic [5:0] F_SLL = 6'h00, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_SYSCALL = 6'h0c, F_MTHI = 6'h11, F_MULT = 6'h18, F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22, F_NOR = 6'h27, F_SLT = 6'h2a;

    typedef struct packed {
        logic       pc_wr, pc_wr_cond;
        logic [1:0] pc_src;
        logic       ir_wr, iord, mem_read, mem_wr, mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_wr, src_a;
        logic [2:0] src_b;
        logic [5:0] alu_op;
        logic       sign_ext, muldiv_start, exc;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic       ack;
        logic [5:0] op;
        logic [5:0] funct;
    } step_t;

    logic       clk = 1'b0;
    logic       reset, ack;
    logic [5:0] op, funct;
    logic       pc_wr, pc_wr_cond, ir_wr, iord, mem_read, mem_wr, mem_to_reg, reg_wr, src_a;
    logic       sign_ext, muldiv_start, exc;
    logic [1:0] pc_src, reg_dst;
    logic [2:0] src_b;
    logic [5:0] alu_op;
    logic [3:0] st;
    ctl_t       got;

    step_t      q[$];
    int         trace[$];
    int         tests = 0;
    int         fails = 0;
    int         pulses;
    logic [5:0] cur_op, cur_funct;
    logic [5:0] exec_alu;
    logic [2:0] exec_src_b;

    always #5 clk = ~clk;

    mips_multicycle_control #(
        .ALU_OP_W      (6),
        .ALU_SRC_W     (3),
        .MULDIV_CYCLES (MdCycles)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .instr_op_ctl_i     (op),
        .instr_funct_ctl_i  (funct),
        .mem_ack_i          (ack),
        .pc_wr_ctl_o        (pc_wr),
        .pc_wr_cond_ctl_o   (pc_wr_cond),
        .pc_src_ctl_o       (pc_src),
        .ir_wr_ctl_o        (ir_wr),
        .iord_ctl_o         (iord),
        .mem_read_ctl_o     (mem_read),
        .mem_wr_ctl_o       (mem_wr),
        .mem_to_reg_ctl_o   (mem_to_reg),
        .reg_dst_ctl_o      (reg_dst),
        .reg_wr_ctl_o       (reg_wr),
        .alu_src_a_ctl_o    (src_a),
        .alu_src_b_ctl_o    (src_b),
        .alu_op_ctl_o       (alu_op),
        .sign_ext_ctl_o     (sign_ext),
        .muldiv_start_ctl_o (muldiv_start),
        .state_o            (st)
`ifdef MIPS_MC_CTRL_EXC_EN
        ,
        .exc_ctl_o          (exc)
`endif
    );

`ifndef MIPS_MC_CTRL_EXC_EN
    assign exc = 1'b0;
`endif

    always_comb begin
        got = '{pc_wr, pc_wr_cond, pc_src, ir_wr, iord, mem_read, mem_wr, mem_to_reg, reg_dst,
                reg_wr, src_a, src_b, alu_op, sign_ext, muldiv_start, exc, st};
    end

    function automatic ctl_t mk(input int s);
        ctl_t c = '0;
        c.st = 4'(s);
        return c;
    endfunction

    function automatic logic [5:0] r_alu(input logic [5:0] f);
        case (f)
            6'h22, 6'h23: return 6'b000001;
            6'h24:        return 6'b010000;
            6'h25:        return 6'b001000;
            6'h26:        return 6'b100000;
            6'h27:        return 6'b011000;
            6'h2a:        return 6'b101001;
            6'h2b:        return 6'b110001;
            6'h00, 6'h04: return 6'b000010;
            6'h02, 6'h06: return 6'b000100;
            6'h03, 6'h07: return 6'b000110;
            default:      return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] i_alu(input logic [5:0] o);
        case (o)
            OP_SLTI:  return 6'b101001;
            OP_SLTIU: return 6'b110001;
            OP_ANDI:  return 6'b010000;
            OP_ORI:   return 6'b001000;
            OP_XORI:  return 6'b100000;
            default:  return 6'b000000;
        endcase
    endfunction

    task automatic push(input ctl_t c, input logic a);
        step_t s;
        s.c = c; s.ack = a; s.op = cur_op; s.funct = cur_funct;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycle-by-cycle control trace.
    task automatic model(input logic [5:0] o, input logic [5:0] f, input int fd, input int md,
                         input logic noise);
        ctl_t c;
        logic is_r;
        cur_op = o; cur_funct = f;
        is_r = (o == OP_R);
        for (int i = 0; i <= fd; i++) begin
            c = mk(1); c.mem_read = 1'b1; c.src_b = 3'b101;
            if (i == fd) begin c.ir_wr = 1'b1; c.pc_wr = 1'b1; end
            push(c, i == fd);
        end
        c = mk(2); c.src_b = 3'b011; push(c, noise);
        if (o == OP_LW || o == OP_SW) begin
            c = mk(3); c.src_a = 1'b1; c.src_b = 3'b001; c.sign_ext = 1'b1; push(c, noise);
            for (int i = 0; i <= md; i++) begin
                c = mk(o == OP_LW ? 4 : 6); c.iord = 1'b1;
                if (o == OP_LW) c.mem_read = 1'b1; else c.mem_wr = 1'b1;
                push(c, i == md);
            end
            if (o == OP_LW) begin
                c = mk(5); c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; push(c, noise);
            end
        end else if (o == OP_J || o == OP_JAL || (is_r && (f == F_JR || f == F_JALR))) begin
            c = mk(10); c.pc_wr = 1'b1; c.pc_src = is_r ? 2'b11 : 2'b10;
            if (o == OP_JAL || (is_r && f == F_JALR)) begin
                c.reg_wr = 1'b1; c.src_b = 3'b101; c.reg_dst = (o == OP_JAL) ? 2'b10 : 2'b01;
            end
            push(c, noise);
        end else if (o inside {OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) begin
            c = mk(9); c.src_a = 1'b1; c.pc_wr_cond = 1'b1; c.pc_src = 2'b01;
            c.alu_op = 6'b000001; c.src_b = (o inside {OP_BEQ, OP_BNE}) ? 3'b000 : 3'b100;
            push(c, noise);
        end else if (is_r) begin
            c = mk(7); c.src_a = 1'b1; c.alu_op = r_alu(f);
            c.src_b = (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) ? 3'b010 : 3'b000;
            if (f inside {6'h18, 6'h19, 6'h1a, 6'h1b}) begin
                c.muldiv_start = 1'b1; push(c, noise);
                for (int i = 0; i < int'(MdCycles); i++) push(mk(11), noise);
            end else if (f == F_SYSCALL) begin
                push(c, noise);
`ifdef MIPS_MC_CTRL_EXC_EN
                c = mk(12); c.exc = 1'b1; c.pc_wr = 1'b1; push(c, noise);
`endif
            end else if (f == F_MTHI || f == 6'h13) begin
                push(c, noise);
            end else begin
                push(c, noise);
                c = mk(8); c.reg_wr = 1'b1; c.reg_dst = 2'b01; push(c, noise);
            end
        end else if (o inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI})
        begin
            c = mk(7); c.src_a = 1'b1; c.src_b = 3'b001; c.alu_op = i_alu(o);
            c.sign_ext = !(o inside {OP_ANDI, OP_ORI, OP_XORI});
            push(c, noise);
            c = mk(8); c.reg_wr = 1'b1; push(c, noise);
        end else begin
            c = mk(12);
`ifdef MIPS_MC_CTRL_EXC_EN
            c.exc = 1'b1; c.pc_wr = 1'b1;
`endif
            push(c, noise);
        end
    endtask

    task automatic check_ctl(input string name, input ctl_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t state=%0d got=%h expected=%h", name, $time, got.st, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Single compare process: drive each step after the edge, check at the falling edge.
    task automatic run();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(posedge clk);
            #1;
            ack = s.ack; op = s.op; funct = s.funct;
            @(negedge clk);
            check_ctl("cycle", s.c);
            trace.push_back(int'(got.st));
            if (got.muldiv_start) pulses++;
            if (got.st == 4'd7) begin exec_alu = got.alu_op; exec_src_b = got.src_b; end
        end
    endtask

    function automatic int count_state(input int s);
        int n = 0;
        foreach (trace[i]) if (trace[i] == s) n++;
        return n;
    endfunction

    initial begin
        int   lw_exp[11] = '{1, 1, 1, 1, 2, 3, 4, 4, 4, 4, 5};
        ctl_t fetch_c;
        reset = 1'b0; ack = 1'b0; op = 6'h00; funct = 6'h00;
        #1 reset = 1'b1;
        @(negedge clk);
        check_ctl("reset_idle", mk(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        fetch_c = mk(1); fetch_c.mem_read = 1'b1; fetch_c.src_b = 3'b101;
        check_ctl("fetch_after_release", fetch_c);
        check_int("fetch_iord", int'(iord), 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_ctl("reset_mid_fetch", mk(0));
        @(negedge clk);
        reset = 1'b0;

        trace.delete();
        model(OP_LW, 6'h00, 3, 3, 1'b0);
        run();
        check_int("lw_trace_len", trace.size(), 11);
        foreach (lw_exp[i]) if (i < trace.size()) check_int("lw_trace", trace[i], lw_exp[i]);

        model(OP_SW, 6'h00, 0, 2, 1'b1);
        run();

        model(OP_ORI, 6'h00, 1, 0, 1'b0);
        run();
        check_int("ori_alu_op", int'(exec_alu), 8);
        check_int("ori_src_b", int'(exec_src_b), 1);

        trace.delete(); pulses = 0;
        model(OP_R, F_MULT, 0, 0, 1'b0);
        run();
        check_int("mult_cycles", count_state(11), 4);
        check_int("mult_pulses", pulses, 1);

        model(OP_ADDI, 6'h00, 0, 0, 1'b1);
        model(OP_R, F_ADD, 0, 0, 1'b1);
        model(OP_R, F_SRAV, 1, 0, 1'b0);
        model(OP_R, F_SLL, 0, 0, 1'b0);
        model(OP_R, F_NOR, 0, 0, 1'b1);
        model(OP_R, F_SUB, 0, 0, 1'b0);
        model(OP_R, F_SLT, 0, 0, 1'b0);
        model(OP_XORI, 6'h00, 0, 0, 1'b0);
        model(OP_SLTIU, 6'h00, 0, 0, 1'b0);
        model(OP_R, F_MTHI, 0, 0, 1'b1);
        model(OP_R, F_SYSCALL, 0, 0, 1'b0);
        model(OP_BLEZ, 6'h00, 0, 0, 1'b0);
        model(OP_BEQ, 6'h00, 0, 0, 1'b1);
        model(OP_REGIMM, 6'h00, 0, 0, 1'b0);
        model(OP_J, 6'h00, 0, 0, 1'b0);
        model(OP_JAL, 6'h00, 2, 0, 1'b0);
        model(OP_R, F_JR, 0, 0, 1'b0);
        model(OP_R, F_JALR, 0, 0, 1'b1);
        run();

        trace.delete();
        model(OP_BAD, 6'h00, 0, 0, 1'b0);
        model(OP_SW, 6'h00, 0, 0, 1'b0);
        run();
        check_int("illegal_trap_cycles", count_state(12), 1);
        check_int("illegal_then_fetch", trace[3], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
